// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the 1-bit colour expander used by the scanout path.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_W     = H_ACTIVE / 2;
  localparam int FB_H     = V_ACTIVE / 2;
  localparam int ADDR_W   = 17;
  localparam int COLOUR_W = 3;

  function automatic logic [7:0] expand(input logic b);
    return {8{b}};
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Pixel tick generator plus h/v raster counters and the undelayed sync/active decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FPR = H_FP,
  parameter int H_SYN = H_SYNC,
  parameter int H_BPR = H_BP,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FPR = V_FP,
  parameter int V_SYN = V_SYNC,
  parameter int V_BPR = V_BP
) (
  input  logic       clock,
  input  logic       resetn,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       line_wrap,
  output logic       frame_wrap,
  output logic       vblank
);
  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FPR + H_SYN + H_BPR - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FPR + V_SYN + V_BPR - 1);
  localparam logic [9:0] HA     = 10'(H_ACT);
  localparam logic [9:0] VA     = 10'(V_ACT);
  localparam logic [9:0] HS_ON  = 10'(H_ACT + H_FPR);
  localparam logic [9:0] HS_OFF = 10'(H_ACT + H_FPR + H_SYN);
  localparam logic [9:0] VS_ON  = 10'(V_ACT + V_FPR);
  localparam logic [9:0] VS_OFF = 10'(V_ACT + V_FPR + V_SYN);

  assign line_wrap  = tick && (h == H_LAST);
  assign frame_wrap = line_wrap && (v == V_LAST);
  assign active     = (h < HA) && (v < VA);
  assign hs_raw     = !((h >= HS_ON) && (h < HS_OFF));
  assign vs_raw     = !((v >= VS_ON) && (v < VS_OFF));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick   <= 1'b0;
      h      <= '0;
      v      <= '0;
      vblank <= 1'b0;
    end else begin
      tick   <= ~tick;
      // fires on the tick that moves the raster onto the first blank line
      vblank <= line_wrap && (v == VA - 10'd1);
      if (line_wrap) begin
        h <= '0;
        v <= frame_wrap ? '0 : v + 10'd1;
      end else if (tick) begin
        h <= h + 10'd1;
      end
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// Framebuffer raster reader: 2x2 pixel-doubled address generation and the VGA pin pipeline.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FPR = H_FP,
  parameter int H_SYN = H_SYNC,
  parameter int H_BPR = H_BP,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FPR = V_FP,
  parameter int V_SYN = V_SYNC,
  parameter int V_BPR = V_BP
) (
  input  logic                clock,
  input  logic                resetn,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [COLOUR_W-1:0] rd_data,
  output logic                vblank_start,
  output logic                VGA_CLK,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B
);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACT / 2);
  localparam logic [9:0]        VA        = 10'(V_ACT);

  logic              tick, active, hs_raw, vs_raw, line_wrap, frame_wrap;
  logic [9:0]        h, v;
  logic [ADDR_W-1:0] line_base;
  logic              act_d, hs_d, vs_d;

  vga_timing #(
    .H_ACT(H_ACT), .H_FPR(H_FPR), .H_SYN(H_SYN), .H_BPR(H_BPR),
    .V_ACT(V_ACT), .V_FPR(V_FPR), .V_SYN(V_SYN), .V_BPR(V_BPR)
  ) u_timing (
    .clock      (clock),
    .resetn     (resetn),
    .tick       (tick),
    .h          (h),
    .v          (v),
    .active     (active),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .line_wrap  (line_wrap),
    .frame_wrap (frame_wrap),
    .vblank     (vblank_start)
  );

  assign VGA_SYNC_N = 1'b0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      VGA_CLK     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      line_base   <= '0;
      act_d       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else begin
      // one clock behind tick, so it reads as ~tick once out of reset
      VGA_CLK <= tick;
      rd_en   <= tick && active;
      if (tick && active) rd_addr <= line_base + ADDR_W'(h[9:1]);
      // line pairs share a base; step only after the odd line of a visible pair
      if (line_wrap) begin
        if (frame_wrap)            line_base <= '0;
        else if (v[0] && (v < VA)) line_base <= line_base + LINE_STEP;
      end
      if (tick) begin
        act_d       <= active;
        hs_d        <= hs_raw;
        vs_d        <= vs_raw;
        VGA_BLANK_N <= act_d;
        VGA_HS      <= hs_d;
        VGA_VS      <= vs_d;
        VGA_R       <= act_d ? expand(rd_data[2]) : 8'h00;
        VGA_G       <= act_d ? expand(rd_data[1]) : 8'h00;
        VGA_B       <= act_d ? expand(rd_data[0]) : 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench: full-size and shrunken-geometry scanouts against a raster-position reference model.
module tb_vga_scanout;
  import vga_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } geom_t;

  typedef struct {
    int rd_en, rd_addr, vblank, vclk, hs, vs, blank_n, sync_n, r, g, b;
  } outs_t;

  geom_t gb = '{640, 16, 96, 48, 480, 10, 2, 33};
  geom_t gs = '{16, 2, 4, 2, 8, 2, 1, 2};

  logic clock = 1'b0;
  always #10 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic run = 1'b0;

  // full-size instance
  logic              rstn_b, rd_en_b, vbl_b, vclk_b, hs_b, vs_b, bn_b, sn_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [2:0]        rd_data_b, key_b;
  logic [7:0]        r_b, g_b, b_b;
  int                e_b;

  // small-geometry instance: whole frames fit in a short run
  logic              rstn_s, rd_en_s, vbl_s, vclk_s, hs_s, vs_s, bn_s, sn_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [2:0]        rd_data_s, key_s;
  logic [7:0]        r_s, g_s, b_s;
  int                e_s;

  vga_scanout u_big (
    .clock(clock), .resetn(rstn_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .vblank_start(vbl_b), .VGA_CLK(vclk_b), .VGA_HS(hs_b),
    .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  vga_scanout #(
    .H_ACT(16), .H_FPR(2), .H_SYN(4), .H_BPR(2),
    .V_ACT(8), .V_FPR(2), .V_SYN(1), .V_BPR(2)
  ) u_small (
    .clock(clock), .resetn(rstn_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .rd_data(rd_data_s), .vblank_start(vbl_s), .VGA_CLK(vclk_s), .VGA_HS(hs_s),
    .VGA_VS(vs_s), .VGA_BLANK_N(bn_s), .VGA_SYNC_N(sn_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
  );

  // 1-clock-latency RAMs; data is garbage whenever no read was issued
  always @(posedge clock) begin
    rd_data_b <= rd_en_b ? (rd_addr_b[2:0] ^ key_b) : 3'($urandom);
    rd_data_s <= rd_en_s ? (rd_addr_s[2:0] ^ key_s) : 3'($urandom);
    cyc <= cyc + 1;
  end

  always @(posedge clock or negedge rstn_b) if (!rstn_b) e_b <= 0; else e_b <= e_b + 1;
  always @(posedge clock or negedge rstn_s) if (!rstn_s) e_s <= 0; else e_s <= e_s + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int fb_addr(int h, int v, geom_t g);
    return (v / 2) * (g.ha / 2) + h / 2;
  endfunction

  // e = clock edges since reset release; pixel k is fetched on edge 2+2k, shown from edge 4+2k
  function automatic outs_t model(int e, geom_t g, logic [2:0] key);
    outs_t x;
    int ht, frame, k, pos, h, v, word;
    bit act;
    ht    = g.ha + g.hf + g.hs + g.hb;
    frame = ht * (g.va + g.vf + g.vs + g.vb);
    x = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    x.vclk = (e >= 1 && e % 2 == 0) ? 1 : 0;
    if (e >= 2) begin
      k = (e - e % 2 - 2) / 2;
      pos = k % frame;
      h = pos % ht;
      v = pos / ht;
      act = (h < g.ha) && (v < g.va);
      if (act)            x.rd_addr = fb_addr(h, v, g);
      else if (v < g.va)  x.rd_addr = fb_addr(g.ha - 1, v, g);
      else                x.rd_addr = fb_addr(g.ha - 1, g.va - 1, g);
      if (e % 2 == 0) begin
        x.rd_en  = act ? 1 : 0;
        x.vblank = (pos == (g.va - 1) * ht + ht - 1) ? 1 : 0;
      end
    end
    if (e >= 4) begin
      k = (e - e % 2 - 4) / 2;
      pos = k % frame;
      h = pos % ht;
      v = pos / ht;
      act = (h < g.ha) && (v < g.va);
      x.blank_n = act ? 1 : 0;
      x.hs = (h >= g.ha + g.hf && h < g.ha + g.hf + g.hs) ? 0 : 1;
      x.vs = (v >= g.va + g.vf && v < g.va + g.vf + g.vs) ? 0 : 1;
      if (act) begin
        word = int'(3'(fb_addr(h, v, g)) ^ key);
        x.r = word[2] ? 255 : 0;
        x.g = word[1] ? 255 : 0;
        x.b = word[0] ? 255 : 0;
      end
    end
    return x;
  endfunction

  task automatic cmp(input string who, input outs_t o, input outs_t x);
    chk({who, ".rd_en"},   o.rd_en,   x.rd_en);
    chk({who, ".rd_addr"}, o.rd_addr, x.rd_addr);
    chk({who, ".vblank"},  o.vblank,  x.vblank);
    chk({who, ".vga_clk"}, o.vclk,    x.vclk);
    chk({who, ".hs"},      o.hs,      x.hs);
    chk({who, ".vs"},      o.vs,      x.vs);
    chk({who, ".blank_n"}, o.blank_n, x.blank_n);
    chk({who, ".sync_n"},  o.sync_n,  x.sync_n);
    chk({who, ".r"},       o.r,       x.r);
    chk({who, ".g"},       o.g,       x.g);
    chk({who, ".b"},       o.b,       x.b);
  endtask

  always @(negedge clock) begin
    if (run) begin
      cmp("big", '{int'(rd_en_b), int'(rd_addr_b), int'(vbl_b), int'(vclk_b), int'(hs_b),
                   int'(vs_b), int'(bn_b), int'(sn_b), int'(r_b), int'(g_b), int'(b_b)},
          model(e_b, gb, key_b));
      cmp("small", '{int'(rd_en_s), int'(rd_addr_s), int'(vbl_s), int'(vclk_s), int'(hs_s),
                     int'(vs_s), int'(bn_s), int'(sn_s), int'(r_s), int'(g_s), int'(b_s)},
          model(e_s, gs, key_s));
    end
  end

  // pulse-width / period / per-frame measurements on the pins
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int   hs_fall = -1, vs_fall = -1, vbl_cnt = 0, max_s = 0;
  always @(negedge clock) begin
    if (!rstn_b) begin
      hs_prev <= 1'b1;
      hs_fall <= -1;
    end else begin
      hs_prev <= hs_b;
      if (hs_prev && !hs_b) begin
        if (hs_fall >= 0 && run) chk("hs_period", cyc - hs_fall, 1600);
        hs_fall <= cyc;
      end
      if (!hs_prev && hs_b && hs_fall >= 0 && run) chk("hs_low", cyc - hs_fall, 192);
    end
    if (!rstn_s) begin
      vs_prev <= 1'b1;
      vs_fall <= -1;
      vbl_cnt <= 0;
      max_s   <= 0;
    end else begin
      vs_prev <= vs_s;
      if (vs_prev && !vs_s) begin
        if (vs_fall >= 0 && run) begin
          chk("vs_period", cyc - vs_fall, 624);
          chk("vblank_per_frame", vbl_cnt, 1);
          chk("max_addr_per_frame", max_s, 31);
        end
        vs_fall <= cyc;
        vbl_cnt <= int'(vbl_s);
        max_s   <= 0;
      end else begin
        vbl_cnt <= vbl_cnt + int'(vbl_s);
        if (rd_en_s && int'(rd_addr_s) > max_s) max_s <= int'(rd_addr_s);
      end
      if (!vs_prev && vs_s && vs_fall >= 0 && run) chk("vs_low", cyc - vs_fall, 48);
    end
  end

  task automatic wait_eb(input int target);
    int n = 0;
    while (e_b != target && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("wait_edge", e_b, target);
  endtask

  task automatic check_reset_pins(input string who, input logic en, input logic [ADDR_W-1:0] a,
                                  input logic hs, input logic vs, input logic bn,
                                  input logic vc, input logic [7:0] r);
    chk({who, ".rst_rd_en"},   int'(en), 0);
    chk({who, ".rst_rd_addr"}, int'(a),  0);
    chk({who, ".rst_hs"},      int'(hs), 1);
    chk({who, ".rst_vs"},      int'(vs), 1);
    chk({who, ".rst_blank_n"}, int'(bn), 0);
    chk({who, ".rst_vga_clk"}, int'(vc), 0);
    chk({who, ".rst_r"},       int'(r),  0);
  endtask

  initial begin
    rstn_b = 1'b0;
    rstn_s = 1'b0;
    key_b  = 3'd0;
    key_s  = 3'($urandom);
    repeat (5) @(posedge clock);
    #1 run = 1'b1;
    @(negedge clock);
    #1;
    check_reset_pins("big", rd_en_b, rd_addr_b, hs_b, vs_b, bn_b, vclk_b, r_b);
    rstn_b = 1'b1;
    rstn_s = 1'b1;

    // first strobe two clocks after release, address 0
    wait_eb(2);
    chk("first_rd_en", int'(rd_en_b), 1);
    chk("first_rd_addr", int'(rd_addr_b), 0);

    // framebuffer word 5 = 3'b101 -> magenta on screen pixel 10 (h=10 reads addr 5)
    wait_eb(24);
    chk("px_addr5_r", int'(r_b), 255);
    chk("px_addr5_g", int'(g_b), 0);
    chk("px_addr5_b", int'(b_b), 255);
    chk("px_addr5_blank_n", int'(bn_b), 1);

    // random mid-frame reset of the small instance
    repeat ($urandom_range(700, 1500)) @(negedge clock);
    #3 rstn_s = 1'b0;
    #1 check_reset_pins("small", rd_en_s, rd_addr_s, hs_s, vs_s, bn_s, vclk_s, r_s);
    key_s = 3'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 rstn_s = 1'b1;

    // mid-line reset of the full-size instance at v=3, h=300
    wait_eb(2 + 2 * (3 * 800 + 300));
    #3 rstn_b = 1'b0;
    #1 check_reset_pins("big_mid", rd_en_b, rd_addr_b, hs_b, vs_b, bn_b, vclk_b, r_b);
    key_b = 3'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 rstn_b = 1'b1;
    wait_eb(2);
    chk("restart_rd_en", int'(rd_en_b), 1);
    chk("restart_rd_addr", int'(rd_addr_b), 0);

    repeat (4000) @(negedge clock);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
